// File: rtl/cla_nibble_sequencer.sv
// Nibble-serial WIDTH-bit adder controller driving an external 4-bit CLA.
// Optional signed overflow output enabled by defining SIGNED_OVF_EN.
module cla_nibble_sequencer #(
    parameter int WIDTH   = 16,
    parameter int CLA_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [3:0]       cla_a,
    output logic [3:0]       cla_b,
    output logic             cla_cin,
    input  logic [3:0]       cla_sum,
    input  logic             cla_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
`ifdef SIGNED_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = (CLA_LAT > 0) ? $clog2(CLA_LAT + 1) : 1;
    localparam logic [IW-1:0] ILAST = IW'(N - 1);
    localparam logic [WW-1:0] WLAST = WW'(CLA_LAT);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("cla_nibble_sequencer: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WW-1:0]    wcnt_q, wcnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic [3:0]       cla_a_q, cla_a_d;
    logic [3:0]       cla_b_q, cla_b_d;
    // cla_cin_q doubles as the running inter-nibble carry
    logic             cla_cin_q, cla_cin_d;
`ifdef SIGNED_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic          accept;
    logic          smp;
    logic          last;
    logic [IW-1:0] idx_nx;

    assign accept = (state_q == IDLE) && in_valid && !reset;
    assign smp    = (state_q == RUN) && (wcnt_q == WLAST);
    assign last   = (idx_q == ILAST);
    assign idx_nx = idx_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            wcnt_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            cla_a_q   <= '0;
            cla_b_q   <= '0;
            cla_cin_q <= 1'b0;
`ifdef SIGNED_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wcnt_q    <= wcnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            cla_a_q   <= cla_a_d;
            cla_b_q   <= cla_b_d;
            cla_cin_q <= cla_cin_d;
`ifdef SIGNED_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (smp && last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d     = idx_q;
        wcnt_d    = wcnt_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        cla_a_d   = cla_a_q;
        cla_b_d   = cla_b_q;
        cla_cin_d = cla_cin_q;
`ifdef SIGNED_OVF_EN
        ovf_d     = ovf_q;
`endif
        if (accept) begin
            a_d       = in_a;
            b_d       = in_b;
            idx_d     = '0;
            wcnt_d    = '0;
            cla_a_d   = in_a[3:0];
            cla_b_d   = in_b[3:0];
            cla_cin_d = in_cin;
        end else if (state_q == RUN) begin
            if (smp) begin
                sum_d[4*idx_q +: 4] = cla_sum;
                wcnt_d              = '0;
                cla_cin_d           = cla_cout;
                if (last) begin
                    cout_d = cla_cout;
`ifdef SIGNED_OVF_EN
                    ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                             (cla_sum[3] != a_q[WIDTH-1]);
`endif
                end else begin
                    idx_d   = idx_nx;
                    cla_a_d = a_q[4*idx_nx +: 4];
                    cla_b_d = b_q[4*idx_nx +: 4];
                end
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && !reset;
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        cla_a     = cla_a_q;
        cla_b     = cla_b_q;
        cla_cin   = cla_cin_q;
        out_sum   = sum_q;
        out_cout  = cout_q;
`ifdef SIGNED_OVF_EN
        out_ovf   = ovf_q;
`endif
    end

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Randomized + directed bench for cla_nibble_sequencer against an
// arithmetic reference and a behavioural latency-matched CLA model.
module tb_cla_nibble_sequencer;

    localparam int WIDTH   = 16;
    localparam int CLA_LAT = 1;
    localparam int N       = WIDTH / 4;
    localparam int T       = CLA_LAT + 1;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic [3:0]       cla_a;
    logic [3:0]       cla_b;
    logic             cla_cin;
    logic [3:0]       cla_sum;
    logic             cla_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             busy;
`ifdef SIGNED_OVF_EN
    logic             out_ovf;
`endif

    cla_nibble_sequencer #(.WIDTH(WIDTH), .CLA_LAT(CLA_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .cla_a     (cla_a),
        .cla_b     (cla_b),
        .cla_cin   (cla_cin),
        .cla_sum   (cla_sum),
        .cla_cout  (cla_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
`ifdef SIGNED_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural CLA: plain 4-bit add delayed by CLA_LAT cycles
    logic [4:0] cla_comb;
    logic [4:0] cla_res;
    assign cla_comb = {1'b0, cla_a} + {1'b0, cla_b} + {4'b0, cla_cin};
    if (CLA_LAT == 0) begin : g_comb
        assign cla_res = cla_comb;
    end else begin : g_pipe
        logic [4:0] pipe [CLA_LAT];
        always @(posedge clk) begin
            pipe[0] <= cla_comb;
            for (int i = 1; i < CLA_LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign cla_res = pipe[CLA_LAT-1];
    end
    assign cla_sum  = cla_res[3:0];
    assign cla_cout = cla_res[4];

    int checks = 0;
    int errors = 0;
    int run_cyc;
    int cin_zero;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input string tag);
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = WIDTH'($urandom);
        in_b     = WIDTH'($urandom);
        in_cin   = 1'($urandom);
    endtask

    task automatic finish_op(input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b,
                             input logic cin, input int hold,
                             input string tag);
        logic [WIDTH:0]   ref_v;
        logic [WIDTH-1:0] rs;
        logic             ro;
        ref_v = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        rs    = ref_v[WIDTH-1:0];
        ro    = (a[WIDTH-1] == b[WIDTH-1]) && (rs[WIDTH-1] != a[WIDTH-1]);
        run_cyc  = 0;
        cin_zero = 0;
        while (!out_valid && run_cyc < 200) begin
            if (!cla_cin) cin_zero++;
            run_cyc++;
            @(posedge clk); #1;
        end
        chk({tag, "_latency"}, 64'(run_cyc), 64'(N * T));
        for (int h = 0; h < hold; h++) begin
            chk({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
            chk({tag, "_hold_sum"}, 64'(out_sum), 64'(rs));
            in_valid = (h == 0);
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
        end
        chk({tag, "_sum"}, 64'(out_sum), 64'(rs));
        chk({tag, "_cout"}, 64'(out_cout), 64'(ref_v[WIDTH]));
`ifdef SIGNED_OVF_EN
        chk({tag, "_ovf"}, 64'(out_ovf), 64'(ro));
`else
        if (ro) ro = 1'b0;
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        chk({tag, "_busy_drop"}, 64'(busy), 64'd0);
    endtask

    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input int hold, input string tag);
        send(a, b, cin, tag);
        finish_op(a, b, cin, hold, tag);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_out_cout", 64'(out_cout), 64'd0);
        chk("rst_cla_a", 64'(cla_a), 64'd0);
        chk("rst_cla_b", 64'(cla_b), 64'd0);
        chk("rst_cla_cin", 64'(cla_cin), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        do_op(16'h0003, 16'h0005, 1'b0, 0, "t1");

        do_op(16'hFFFF, 16'h0000, 1'b1, 0, "t2");
        chk("t2_cla_cin_zero", 64'(cin_zero), 64'd0);

        do_op(16'h1234, 16'h1111, 1'b0, 5, "t3");

        send(16'hFFFF, 16'h0001, 1'b0, "t4");
        repeat (2 * T) @(posedge clk);
        #1;
        chk("t4_busy_mid", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("t4_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("t4_out_valid", 64'(out_valid), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_sum_clr", 64'(out_sum), 64'd0);
        do_op(16'h1234, 16'h4321, 1'b0, 0, "t4b");

        do_op(16'h7FFF, 16'h0001, 1'b0, 0, "t5a");
        do_op(16'h8000, 16'h8000, 1'b0, 1, "t5b");

        do_op(16'hA5A5, 16'h5A5A, 1'b1, 0, "t6");

        for (int i = 0; i < 24; i++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
